uart_rx_frame: RTL

//   Parametrised, oversampled UART receiver that assembles N_BYTES serial bytes into one parallel word.

---
 rtl/uart_rx_frame.sv | 316 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// ============================================================================
// uart_rx_frame
// ----------------------------------------------------------------------------
// Oversampled UART receiver. It collects N_BYTES serial bytes and presents
// them as one parallel word with a valid/ready handshake. It also detects
// framing errors, parity errors (optional) and overruns, and rejects short
// low glitches on the line before they can start a frame.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : a parity bit follows the data bits and is checked against
//               PARITY_ODD.
//   undefined : the frame is start + DATA_BITS + stop, and parity_err
//               stays 0.
//
// Ports
//   clk         in   receiver clock, OVERSAMPLE x baud
//   rst_n       in   asynchronous reset, active low
//   rx          in   serial line, idle high, asynchronous to clk
//   data        out  assembled word; byte 0 is in the LSBs
//   valid       out  word available, held until accepted
//   ready       in   consumer takes the word when valid & ready
//   busy        out  receiver not idle, or a partial word is buffered
//   frame_err   out  1-clk pulse: stop bit sampled low
//   parity_err  out  1-clk pulse: parity mismatch
//   overrun     out  1-clk pulse: word completed while the previous one
//                    was still pending
// ============================================================================
module uart_rx_frame #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned N_BYTES    = 2,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rx,
    output logic [DATA_BITS*N_BYTES-1:0]   data,
    output logic                           valid,
    input  logic                           ready,
    output logic                           busy,
    output logic                           frame_err,
    output logic                           parity_err,
    output logic                           overrun
);

    localparam int unsigned WORD_W = DATA_BITS * N_BYTES;
    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam int unsigned IDX_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_BYTES - 1);

    // Elaboration-time parameter range checks
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_rx_frame: DATA_BITS must be 5..9");
    end
    if (N_BYTES < 1 || N_BYTES > 8) begin : g_chk_n_bytes
        $error("uart_rx_frame: N_BYTES must be 1..8");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_chk_oversample
        $error("uart_rx_frame: OVERSAMPLE must be even and >= 4");
    end
    if (PARITY_ODD > 1) begin : g_chk_parity_odd
        $error("uart_rx_frame: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;
`endif

    // Registers
    logic                 r_rx_s1;
    logic                 r_rx_s2;
    state_t               r_state;
    logic [TICK_W-1:0]    r_tick;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_idx;
    logic [WORD_W-1:0]    r_word;
    logic [WORD_W-1:0]    r_data;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    // Next-state values
    logic                 w_rx_s;
    state_t               w_state_nxt;
    logic [TICK_W-1:0]    w_tick_nxt;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [WORD_W-1:0]    w_word_nxt;
    logic [WORD_W-1:0]    w_data_nxt;
    logic                 w_valid_nxt;
    logic                 w_busy_nxt;
    logic                 w_frame_err_nxt;
    logic                 w_parity_err_nxt;
    logic                 w_overrun_nxt;
    logic                 w_par_bad;

`ifdef UART_RX_PARITY_EN
    // Running XOR of data and parity bits, seeded with PARITY_ODD so that a
    // non-zero result always means a mismatch.
    logic r_par_acc;
    logic w_par_acc_nxt;
    assign w_par_bad = r_par_acc;
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_rx_s = r_rx_s2;

    // Next-state, datapath and output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_tick_nxt       = r_tick;
        w_bit_nxt        = r_bit;
        w_shift_nxt      = r_shift;
        w_idx_nxt        = r_idx;
        w_word_nxt       = r_word;
        w_data_nxt       = r_data;
        w_valid_nxt      = r_valid;
        w_frame_err_nxt  = 1'b0;
        w_parity_err_nxt = 1'b0;
        w_overrun_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_acc_nxt    = r_par_acc;
`endif

        // Handshake; a completion in the same cycle below overrides this
        if (r_valid && ready) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                    w_tick_nxt  = '0;
                end
            end

            S_START: begin
                if (r_tick == TICK_MID) begin
                    w_tick_nxt = '0;
                    w_bit_nxt  = '0;
                    // Line back high at mid-start: a glitch, drop silently
                    if (w_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
`ifdef UART_RX_PARITY_EN
                        w_par_acc_nxt = 1'(PARITY_ODD);
`endif
                    end
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end

            S_DATA: begin
                if (r_tick == TICK_LAST) begin
                    w_tick_nxt  = '0;
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                    w_par_acc_nxt = r_par_acc ^ w_rx_s;
`endif
                    if (r_bit == BIT_LAST) begin
                        w_bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_tick == TICK_LAST) begin
                    w_tick_nxt    = '0;
                    w_par_acc_nxt = r_par_acc ^ w_rx_s;
                    w_state_nxt   = S_STOP;
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end
`endif

            S_STOP: begin
                if (r_tick == TICK_LAST) begin
                    w_tick_nxt       = '0;
                    w_parity_err_nxt = w_par_bad;
                    if (!w_rx_s) begin
                        // Framing error: drop the whole partial word
                        w_frame_err_nxt = 1'b1;
                        w_idx_nxt       = '0;
                        w_state_nxt     = S_WAIT_HI;
                    end else if (w_par_bad) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_word_nxt[32'(r_idx)*DATA_BITS +: DATA_BITS] = r_shift;
                        if (r_idx == IDX_LAST) begin
                            w_idx_nxt = '0;
                            if (!r_valid || ready) begin
                                w_data_nxt  = w_word_nxt;
                                w_valid_nxt = 1'b1;
                            end else begin
                                w_overrun_nxt = 1'b1;
                            end
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end

            // Hold off start detection while the line sits low (break)
            S_WAIT_HI: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_tick_nxt  = '0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE) || (w_idx_nxt != '0);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_state      <= S_IDLE;
            r_tick       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_rx_s1      <= rx;
            r_rx_s2      <= r_rx_s1;
            r_state      <= w_state_nxt;
            r_tick       <= w_tick_nxt;
            r_bit        <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_idx        <= w_idx_nxt;
            r_word       <= w_word_nxt;
            r_data       <= w_data_nxt;
            r_valid      <= w_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_parity_err <= w_parity_err_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_acc <= 1'b0;
        end else begin
            r_par_acc <= w_par_acc_nxt;
        end
    end
`endif

    assign data       = r_data;
    assign valid      = r_valid;
    assign busy       = r_busy;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;

endmodule
